writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have parameter N, default 64, meaning XLEN (register/data width, 32 or 64).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning ALU result FIFO depth (power of two, >=2).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, listed first as: clk  input  1  clock (all state on rising edge); rst_n  input  1  asynchronous active-low reset.
REQ-004 aluValid  input  1  ALU result valid; aluReady  output  1  ALU result accepted when both high at an edge.
REQ-005 aluRd  input  5  ALU destination register; aluData  input  N  ALU result.
REQ-006 memValid  input  1  load result valid; memReady  output  1  load result accepted when both high; memRd  input  5; memData  input  N.
REQ-007 issueValid  input  1  instruction issued, mark destination pending; issueRd  input  5  destination being issued.
REQ-008 queryRs1, queryRs2  input  5  source registers to check; busy1, busy2  output  1  source has a pending write.
REQ-009 writeEnable  output  1; rd  output  5; writerData  output  N -- register-file write port, registered.

Function
REQ-010 ALU results SHALL enter a DEPTH-entry FIFO; aluReady SHALL equal not-full, with no same-cycle push-at-full even if a pop occurs.
REQ-011 Load results SHALL enter a single-entry holding register; memReady SHALL equal holding-register-empty.
REQ-012 Each cycle at most one entry SHALL be selected: holding register first, else FIFO head; the selected entry SHALL be removed at that edge.
REQ-013 Selection at edge E SHALL drive writeEnable=1, rd and writerData after edge E; writeEnable SHALL be 0 otherwise (single-cycle pulse per entry).
REQ-014 Latency SHALL be 2 edges from acceptance to writeEnable when uncontended; a result accepted into an empty queue SHALL NOT be selected at its acceptance edge.
REQ-015 An entry with rd=0 SHALL be dequeued normally but SHALL produce writeEnable=0.
REQ-016 Scoreboard: 32 pending bits; issueValid SHALL set bit issueRd at the edge; a commit (writeEnable high) SHALL clear bit rd at the next edge.
REQ-017 Simultaneous set and clear of the same register SHALL leave the bit set; register 0 SHALL never be pending.
REQ-018 busy1/busy2 SHALL be combinational reads of the pending bits for queryRs1/queryRs2.
REQ-019 ALU FIFO order SHALL be preserved; load-vs-ALU ordering SHALL follow REQ-012 only.

Reset
REQ-020 While rst_n=0: FIFO and holding register empty, scoreboard cleared, writeEnable=0, rd=0, writerData=0, aluReady=1, memReady=1, busy1=busy2=0.
REQ-021 Reset asserted mid-operation SHALL discard all queued results and pending bits immediately, with no write issued.

Configuration
REQ-022 Macro WB_BYPASS_EN SHALL, when defined, add outputs fwd1Valid, fwd2Valid (1) and fwd1Data, fwd2Data (N).
REQ-023 With WB_BYPASS_EN: fwdXValid=1 when writeEnable=1, rd!=0 and rd==queryRsX; fwdXData=writerData; busyX SHALL be forced 0 in that cycle.
REQ-024 Without WB_BYPASS_EN the fwd ports SHALL NOT exist and busyX SHALL stay 1 until the clearing edge.

Structure
REQ-025 Package wb_pkg SHALL hold XLEN default, REG_ADDR_W=5 and typedef wb_entry_t {rd, data}.
REQ-026 The FIFO SHALL be sub-module wb_fifo (parameters N, DEPTH; push/pop/full/empty/head).

Verification
REQ-027 After reset, ALU push rd=5 data=0xAA -> writeEnable=1, rd=5, writerData=0xAA two edges later, for one cycle.
REQ-028 Load (rd=7, 0x11) and ALU (rd=3, 0x22) accepted at the same edge -> rd=7 written first, rd=3 next cycle.
REQ-029 Five ALU pushes with memory path busy, DEPTH=4 -> aluReady=0 after the 4th; all four drain in order afterwards.
REQ-030 Issue rd=9, query rs1=9 -> busy1=1; commit rd=9 -> busy1=0 after the clearing edge (0 during commit with WB_BYPASS_EN, fwd1Data=commit data).
REQ-031 ALU push rd=0 -> entry drained, writeEnable stays 0; issueRd=0 -> busy never set.
REQ-032 rst_n pulsed low with 3 queued entries and pending bits -> no writes issue, all busy 0, aluReady=1.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_pkg : shared widths, write-back entry type and helpers for writeback_unit|
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package wb_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] r);
        return (r == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_fifo : DEPTH-entry FIFO holding {rd, data} ALU results (show-ahead head) |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module wb_fifo
    import wb_pkg::*;
#(
    parameter int N     = XLEN,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [REG_ADDR_W+N-1:0] push_data,
    input  logic                    pop,
    output logic                    full,
    output logic                    empty,
    output logic [REG_ADDR_W+N-1:0] head
);

    localparam int          c_AW      = $clog2(DEPTH);
    localparam int          c_W       = REG_ADDR_W + N;
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [c_W-1:0]  r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | writeback_unit : merges ALU/load results into one RF write port + scoreboard|
// | Optional WB_BYPASS_EN adds commit-cycle forwarding ports.      Rev 1.0      |
// +----------------------------------------------------------------------------+
module writeback_unit
    import wb_pkg::*;
#(
    parameter int N     = XLEN,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  aluValid,
    output logic                  aluReady,
    input  logic [REG_ADDR_W-1:0] aluRd,
    input  logic [N-1:0]          aluData,
    input  logic                  memValid,
    output logic                  memReady,
    input  logic [REG_ADDR_W-1:0] memRd,
    input  logic [N-1:0]          memData,
    input  logic                  issueValid,
    input  logic [REG_ADDR_W-1:0] issueRd,
    input  logic [REG_ADDR_W-1:0] queryRs1,
    input  logic [REG_ADDR_W-1:0] queryRs2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  writeEnable,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [N-1:0]          writerData
`ifdef WB_BYPASS_EN
   ,output logic                  fwd1Valid,
    output logic                  fwd2Valid,
    output logic [N-1:0]          fwd1Data,
    output logic [N-1:0]          fwd2Data
`endif
);

    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_fifo_pop;
    logic                    w_alu_push;
    logic [REG_ADDR_W+N-1:0] w_fifo_head;

    wb_entry_t               r_hold;
    logic                    r_hold_valid;
    logic                    w_mem_push;

    wb_entry_t               w_sel;
    logic                    w_sel_valid;

    logic                    r_we;
    logic [REG_ADDR_W-1:0]   r_rd;
    logic [N-1:0]            r_wdata;

    logic [NUM_REGS-1:0]     r_pending;
    logic [NUM_REGS-1:0]     w_pending_nxt;
    logic                    w_busy1_raw;
    logic                    w_busy2_raw;

    assign aluReady   = !w_fifo_full;
    assign w_alu_push = aluValid && !w_fifo_full;
    assign memReady   = !r_hold_valid;
    assign w_mem_push = memValid && !r_hold_valid;

    wb_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_alu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_alu_push),
        .push_data ({aluRd, aluData}),
        .pop       (w_fifo_pop),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .head      (w_fifo_head)
    );

    // Selection looks only at registered state, so a result never bypasses its queue.
    always_comb begin
        w_sel       = r_hold;
        w_sel_valid = r_hold_valid;
        w_fifo_pop  = 1'b0;
        if (!r_hold_valid) begin
            w_sel.rd    = w_fifo_head[N +: REG_ADDR_W];
            w_sel.data  = XLEN'(w_fifo_head[N-1:0]);
            w_sel_valid = !w_fifo_empty;
            w_fifo_pop  = !w_fifo_empty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
        end else if (w_mem_push) begin
            r_hold_valid <= 1'b1;
            r_hold.rd    <= memRd;
            r_hold.data  <= XLEN'(memData);
        end else if (r_hold_valid) begin
            r_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_rd    <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_sel_valid && !is_x0(w_sel.rd);
            if (w_sel_valid) begin
                r_rd    <= w_sel.rd;
                r_wdata <= w_sel.data[N-1:0];
            end
        end
    end

    assign writeEnable = r_we;
    assign rd          = r_rd;
    assign writerData  = r_wdata;

    // A new issue to the register being retired wins over the clear.
    always_comb begin
        w_pending_nxt = r_pending;
        if (r_we)       w_pending_nxt[r_rd]    = 1'b0;
        if (issueValid) w_pending_nxt[issueRd] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= w_pending_nxt;
    end

    assign w_busy1_raw = r_pending[queryRs1];
    assign w_busy2_raw = r_pending[queryRs2];

`ifdef WB_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    assign w_fwd1    = r_we && !is_x0(r_rd) && (r_rd == queryRs1);
    assign w_fwd2    = r_we && !is_x0(r_rd) && (r_rd == queryRs2);
    assign fwd1Valid = w_fwd1;
    assign fwd2Valid = w_fwd2;
    assign fwd1Data  = r_wdata;
    assign fwd2Data  = r_wdata;
    assign busy1     = w_busy1_raw && !w_fwd1;
    assign busy2     = w_busy2_raw && !w_fwd2;
`else
    assign busy1     = w_busy1_raw;
    assign busy2     = w_busy2_raw;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_writeback_unit : directed scoreboard bench for writeback_unit  Rev 1.0   |
// +----------------------------------------------------------------------------+
module tb_writeback_unit;

    localparam int N = 64;
    typedef logic [5+N-1:0] ent_t;

    logic         clk;
    logic         rst_n;
    logic         aluValid;
    logic         aluReady;
    logic [4:0]   aluRd;
    logic [N-1:0] aluData;
    logic         memValid;
    logic         memReady;
    logic [4:0]   memRd;
    logic [N-1:0] memData;
    logic         issueValid;
    logic [4:0]   issueRd;
    logic [4:0]   queryRs1;
    logic [4:0]   queryRs2;
    logic         busy1;
    logic         busy2;
    logic         writeEnable;
    logic [4:0]   rd;
    logic [N-1:0] writerData;
`ifdef WB_BYPASS_EN
    logic         fwd1Valid;
    logic         fwd2Valid;
    logic [N-1:0] fwd1Data;
    logic [N-1:0] fwd2Data;
`endif

    int   n_checks;
    int   n_errors;
    int   alu_sent;
    int   mem_sent;
    logic saw_full;
    ent_t aluq[$];
    ent_t memq[$];
    ent_t mon_got;

    writeback_unit #(
        .N     (N),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .aluValid    (aluValid),
        .aluReady    (aluReady),
        .aluRd       (aluRd),
        .aluData     (aluData),
        .memValid    (memValid),
        .memReady    (memReady),
        .memRd       (memRd),
        .memData     (memData),
        .issueValid  (issueValid),
        .issueRd     (issueRd),
        .queryRs1    (queryRs1),
        .queryRs2    (queryRs2),
        .busy1       (busy1),
        .busy2       (busy2),
        .writeEnable (writeEnable),
        .rd          (rd),
        .writerData  (writerData)
`ifdef WB_BYPASS_EN
       ,.fwd1Valid   (fwd1Valid),
        .fwd2Valid   (fwd2Valid),
        .fwd1Data    (fwd1Data),
        .fwd2Data    (fwd2Data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Records accepted handshakes as expected writes, then advances one edge.
    task automatic tick();
        #1;
        if (rst_n && aluValid && aluReady) begin
            alu_sent++;
            if (aluRd != 5'd0) aluq.push_back({aluRd, aluData});
        end
        if (rst_n && memValid && memReady) begin
            mem_sent++;
            if (memRd != 5'd0) memq.push_back({memRd, memData});
        end
        @(posedge clk);
        #1;
    endtask

    // Loads use rd 7 or rd >= 16; ALU results use the remaining registers.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("we_in_reset", writeEnable, 0);
        end else if (writeEnable) begin
            mon_got = {rd, writerData};
            if (rd >= 5'd16 || rd == 5'd7) begin
                chk("load_write_expected", memq.size() > 0, 1);
                if (memq.size() > 0) chk("load_write", mon_got, memq.pop_front());
            end else begin
                chk("alu_write_expected", aluq.size() > 0, 1);
                if (aluq.size() > 0) chk("alu_write", mon_got, aluq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_errors = 0; alu_sent = 0; mem_sent = 0; saw_full = 1'b0;
        rst_n = 1'b0;
        aluValid = 1'b0; aluRd = '0; aluData = '0;
        memValid = 1'b0; memRd = '0; memData = '0;
        issueValid = 1'b0; issueRd = '0; queryRs1 = '0; queryRs2 = '0;
        tick(); tick();

        // Reset state
        chk("rst_we", writeEnable, 0);
        chk("rst_rd", rd, 0);
        chk("rst_data", writerData, 0);
        chk("rst_aluReady", aluReady, 1);
        chk("rst_memReady", memReady, 1);
        chk("rst_busy1", busy1, 0);
        chk("rst_busy2", busy2, 0);
        rst_n = 1'b1;
        tick();

        // Single ALU result: two-edge latency, one-cycle pulse
        aluValid = 1'b1; aluRd = 5'd5; aluData = 64'hAA;
        tick();
        aluValid = 1'b0;
        chk("alu_not_same_edge", writeEnable, 0);
        tick();
        chk("alu_we", writeEnable, 1);
        chk("alu_rd", rd, 5);
        chk("alu_data", writerData, 64'hAA);
        tick();
        chk("alu_pulse_end", writeEnable, 0);

        // Load and ALU accepted together: load goes first
        memValid = 1'b1; memRd = 5'd7; memData = 64'h11;
        aluValid = 1'b1; aluRd = 5'd3; aluData = 64'h22;
        tick();
        memValid = 1'b0; aluValid = 1'b0;
        tick();
        chk("prio_first_we", writeEnable, 1);
        chk("prio_first_rd", rd, 7);
        tick();
        chk("prio_second_we", writeEnable, 1);
        chk("prio_second_rd", rd, 3);
        tick();
        chk("prio_idle", writeEnable, 0);

        // rd=0 entries drain silently; x0 is never pending
        aluValid = 1'b1; aluRd = 5'd0; aluData = 64'hDEAD;
        tick();
        aluValid = 1'b0;
        tick();
        chk("x0_no_we_sel", writeEnable, 0);
        tick();
        chk("x0_no_we_after", writeEnable, 0);
        issueValid = 1'b1; issueRd = 5'd0; queryRs2 = 5'd0;
        tick();
        issueValid = 1'b0;
        chk("x0_not_busy", busy2, 0);

        // Burst with a competing load stream until the FIFO back-pressures
        alu_sent = 0; mem_sent = 0;
        for (int i = 0; i < 40 && alu_sent < 8; i++) begin
            aluValid = 1'b1; aluRd = 5'(8 + alu_sent); aluData = 64'(32'h100 + alu_sent);
            memValid = 1'b1; memRd = 5'(16 + (mem_sent % 16)); memData = 64'(32'h200 + mem_sent);
            #1;
            if (!aluReady) saw_full = 1'b1;
            tick();
        end
        aluValid = 1'b0; memValid = 1'b0;
        chk("burst_all_sent", alu_sent, 8);
        chk("burst_saw_full", saw_full, 1);
        for (int i = 0; i < 30 && (aluq.size() > 0 || memq.size() > 0); i++) tick();
        tick();
        chk("burst_alu_drained", aluq.size(), 0);
        chk("burst_mem_drained", memq.size(), 0);
        chk("burst_ready_again", aluReady, 1);

        // Scoreboard set / commit clear
        queryRs1 = 5'd9; queryRs2 = 5'd9;
        #1;
        chk("sb_idle_busy1", busy1, 0);
        issueValid = 1'b1; issueRd = 5'd9;
        tick();
        issueValid = 1'b0;
        chk("sb_set_busy1", busy1, 1);
        chk("sb_set_busy2", busy2, 1);
        aluValid = 1'b1; aluRd = 5'd9; aluData = 64'h99;
        tick();
        aluValid = 1'b0;
        chk("sb_wait_busy1", busy1, 1);
        tick();
        chk("sb_commit_we", writeEnable, 1);
`ifdef WB_BYPASS_EN
        chk("sb_commit_busy1_fwd", busy1, 0);
        chk("sb_fwd1_valid", fwd1Valid, 1);
        chk("sb_fwd1_data", fwd1Data, 64'h99);
        chk("sb_fwd2_valid", fwd2Valid, 1);
`else
        chk("sb_commit_busy1", busy1, 1);
        chk("sb_commit_busy2", busy2, 1);
`endif
        tick();
        chk("sb_cleared_busy1", busy1, 0);
        chk("sb_cleared_busy2", busy2, 0);

        // Re-issue on the clearing edge keeps the bit set
        queryRs1 = 5'd10;
        issueValid = 1'b1; issueRd = 5'd10;
        tick();
        issueValid = 1'b0;
        aluValid = 1'b1; aluRd = 5'd10; aluData = 64'hA0;
        tick();
        aluValid = 1'b0;
        tick();
        chk("sw_commit_we", writeEnable, 1);
        issueValid = 1'b1; issueRd = 5'd10;
        tick();
        issueValid = 1'b0;
        chk("sw_set_wins", busy1, 1);
        tick();
        chk("sw_still_busy", busy1, 1);

        // Reset mid-operation with queued results and pending bits
        issueValid = 1'b1; issueRd = 5'd11;
        tick();
        issueRd = 5'd25;
        memValid = 1'b1; memRd = 5'd20; memData = 64'h2020;
        aluValid = 1'b1; aluRd = 5'd11; aluData = 64'h1111;
        tick();
        issueValid = 1'b0;
        memValid = 1'b0; aluRd = 5'd12; aluData = 64'h1212;
        tick();
        memValid = 1'b1; memRd = 5'd21; memData = 64'h2121;
        aluRd = 5'd13; aluData = 64'h1313;
        tick();
        aluValid = 1'b0; memValid = 1'b0;
        queryRs1 = 5'd25; queryRs2 = 5'd10;
        #1;
        chk("mr_pre_busy1", busy1, 1);
        chk("mr_pre_busy2", busy2, 1);
        chk("mr_pre_memReady", memReady, 0);
        rst_n = 1'b0;
        #1;
        aluq.delete();
        memq.delete();
        chk("mr_we", writeEnable, 0);
        chk("mr_busy1", busy1, 0);
        chk("mr_busy2", busy2, 0);
        chk("mr_aluReady", aluReady, 1);
        chk("mr_memReady", memReady, 1);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mr_no_write", writeEnable, 0);
        chk("mr_post_busy1", busy1, 0);
        chk("mr_post_aluReady", aluReady, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
